mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, default 4, max consecutive dmem grants while imem_req is waiting.
REQ-002 clk  in  1  sole clock, all state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 imem_req  in  1  fetch request; held with imem_addr stable until imem_ready or flush.
REQ-005 imem_addr  in  32  fetch address.
REQ-006 imem_flush  in  1  jump taken; kills the pending or in-flight fetch.
REQ-007 imem_rdata  out  32  registered fetch data, valid while imem_ready=1.
REQ-008 imem_ready  out  1  one-cycle completion pulse for fetch.
REQ-009 dmem_req  in  1  data request; held with dmem_we/addr/wdata/wmask stable until dmem_ready.
REQ-010 dmem_we  in  1  1=store, 0=load.
REQ-011 dmem_addr  in  32  data address.
REQ-012 dmem_wdata  in  32  store data.
REQ-013 dmem_wmask  in  4  byte enables.
REQ-014 dmem_rdata  out  32  registered load data, valid while dmem_ready=1.
REQ-015 dmem_ready  out  1  one-cycle completion pulse for data access.
REQ-016 mem_req  out  1  request to shared single-port memory.
REQ-017 mem_we, mem_addr[31:0], mem_wdata[31:0], mem_wmask[3:0]  out  registered copies of the granted requester's fields.
REQ-018 mem_ack  in  1  memory completion, one cycle.
REQ-019 mem_rdata  in  32  memory read data, valid with mem_ack.

Function
REQ-020 FSM states SHALL be IDLE, IBUSY, DBUSY, RESP.
REQ-021 IDLE: dmem_req=1 and (starve_cnt<STARVE_LIMIT or imem_req=0) -> DBUSY; else imem_req=1 and imem_flush=0 -> IBUSY; else stay.
REQ-022 IDLE with starve_cnt==STARVE_LIMIT and imem_req=1 and imem_flush=0 SHALL grant imem even if dmem_req=1.
REQ-023 On grant, mem_req and mem_* fields SHALL be registered in the transition edge; mem_req=1 from the first cycle of IBUSY/DBUSY.
REQ-024 mem_req and mem_* fields SHALL stay constant until the cycle mem_ack=1; memory transactions are never aborted.
REQ-025 mem_ack=1 in IBUSY/DBUSY: mem_req cleared on that edge, mem_rdata captured into owner's rdata register, -> RESP.
REQ-026 RESP (one cycle): owner's ready=1 unless killed; no new grant issued; -> IDLE.
REQ-027 Minimum latency: req seen in IDLE at cycle 0, mem_ack at cycle 1, ready at cycle 2.
REQ-028 imem_flush=1 in any cycle of IBUSY (including the mem_ack cycle) SHALL set a kill flag; RESP then asserts no imem_ready and imem_rdata is not updated.
REQ-029 Kill flag SHALL clear on entry to IDLE.
REQ-030 imem_flush in DBUSY/RESP(dmem) SHALL have no effect.
REQ-031 mem_ack in IDLE or RESP SHALL be ignored.
REQ-032 starve_cnt (width clog2(STARVE_LIMIT+1)): +1 on each dmem grant with imem_req=1, saturating at STARVE_LIMIT; cleared on imem grant or on a dmem grant with imem_req=0.
REQ-033 imem_ready and dmem_ready SHALL never be 1 in the same cycle.
REQ-034 Stores SHALL update dmem_rdata with mem_rdata like loads (value don't-care to requester).

Reset
REQ-035 rst=0 SHALL immediately force state=IDLE, mem_req=0, imem_ready=0, dmem_ready=0, kill=0, starve_cnt=0, all mem_* fields and rdata registers to 0.
REQ-036 Reset mid-transaction SHALL drop the transaction; no ready pulse after rst release.
REQ-037 First grant possible in the first rising edge with rst=1.

Verification
REQ-038 Single load: dmem_req, addr=0x100, mem_ack at cycle 1 with rdata=0xDEADBEEF -> dmem_ready=1, dmem_rdata=0xDEADBEEF at cycle 2.
REQ-039 Simultaneous imem_req/dmem_req in IDLE, starve_cnt=0 -> dmem granted first; imem granted in IDLE after RESP.
REQ-040 dmem_req held continuously with imem_req=1, STARVE_LIMIT=4 -> exactly 4 dmem grants, then imem granted, starve_cnt=0.
REQ-041 Fetch in IBUSY, imem_flush pulsed, mem_ack 3 cycles later -> mem_req held until ack, no imem_ready, imem_rdata unchanged.
REQ-042 rst=0 asserted during DBUSY with mem_req=1 -> mem_req=0 asynchronously, no dmem_ready after release.
REQ-043 mem_ack stalled 10 cycles -> mem_addr/mem_wdata/mem_wmask/mem_we constant throughout, one ready pulse only.

Source files
------------

// File: rtl/mem_arbiter.sv
// Purpose : arbitrates a fetch port (imem) and a data port (dmem) onto one shared
//           single-port memory; dmem has priority, bounded by STARVE_LIMIT.
// Latency : grant on the edge after the request is seen in IDLE. The ready pulse
//           comes one edge after mem_ack, so the minimum is 2 cycles from request.
// Backpr. : requesters hold their fields until ready (flush for imem). A memory
//           transaction is held until mem_ack and is never aborted.
// Ports   : clk, rst (async, active-low); imem_req/addr/flush -> imem_rdata/ready;
//           dmem_req/we/addr/wdata/wmask -> dmem_rdata/ready;
//           mem_req/we/addr/wdata/wmask -> memory, mem_ack/mem_rdata <- memory.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  // fetch port
  input  logic        imem_req,
  input  logic [31:0] imem_addr,
  input  logic        imem_flush,
  output logic [31:0] imem_rdata,
  output logic        imem_ready,
  // data port
  input  logic        dmem_req,
  input  logic        dmem_we,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wmask,
  output logic [31:0] dmem_rdata,
  output logic        dmem_ready,
  // shared memory
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned   CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, IBUSY, DBUSY, RESP} state_t;

  state_t        state_q;
  logic          kill_q;
  logic [CW-1:0] starve_cnt_q;
  logic          grant_dmem_d;
  logic          grant_imem_d;

  // dmem wins unless imem has already waited STARVE_LIMIT dmem grants.
  // A flushed fetch is never granted.
  always_comb begin
    grant_dmem_d = 1'b0;
    grant_imem_d = 1'b0;
    if (state_q == IDLE) begin
      if (dmem_req && ((starve_cnt_q < LIMIT) || !imem_req)) begin
        grant_dmem_d = 1'b1;
      end else if (imem_req && !imem_flush) begin
        grant_imem_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      kill_q       <= 1'b0;
      starve_cnt_q <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wmask    <= '0;
      imem_rdata   <= '0;
      imem_ready   <= 1'b0;
      dmem_rdata   <= '0;
      dmem_ready   <= 1'b0;
    end else begin
      // ready outputs are single-cycle pulses, only raised on the ack edge
      imem_ready <= 1'b0;
      dmem_ready <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_dmem_d) begin
            state_q   <= DBUSY;
            mem_req   <= 1'b1;
            mem_we    <= dmem_we;
            mem_addr  <= dmem_addr;
            mem_wdata <= dmem_wdata;
            mem_wmask <= dmem_wmask;
            // only dmem grants that bypass a waiting fetch count toward starvation
            if (!imem_req) begin
              starve_cnt_q <= '0;
            end else if (starve_cnt_q != LIMIT) begin
              starve_cnt_q <= starve_cnt_q + CW'(1);
            end
          end else if (grant_imem_d) begin
            state_q      <= IBUSY;
            mem_req      <= 1'b1;
            mem_we       <= 1'b0;
            mem_addr     <= imem_addr;
            mem_wdata    <= '0;
            mem_wmask    <= '0;
            starve_cnt_q <= '0;
          end
        end
        IBUSY: begin
          // a flush cannot abort the memory access; it only suppresses the response
          if (imem_flush) begin
            kill_q <= 1'b1;
          end
          if (mem_ack) begin
            state_q <= RESP;
            mem_req <= 1'b0;
            if (!(kill_q || imem_flush)) begin
              imem_rdata <= mem_rdata;
              imem_ready <= 1'b1;
            end
          end
        end
        DBUSY: begin
          if (mem_ack) begin
            state_q    <= RESP;
            mem_req    <= 1'b0;
            dmem_rdata <= mem_rdata;
            dmem_ready <= 1'b1;
          end
        end
        RESP: begin
          // ready pulse is visible during this cycle; no grant until IDLE
          state_q <= IDLE;
          kill_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table, followed by
// starvation, long-stall and reset-during-transaction sequences.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req, imem_flush, imem_ready;
  logic [31:0] imem_addr, imem_rdata;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wmask;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_flush(imem_flush),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_wmask(dmem_wmask),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        ireq, iflush, dreq, dwe, ack;
    logic [31:0] mrd;
    logic        e_mreq, e_mwe;
    logic [31:0] e_maddr;
    logic        e_ir, e_dr;
    logic [31:0] e_irdata, e_drdata;
  } vec_t;

  localparam int NV = 28;
  vec_t vt [NV];

  function automatic vec_t mk(input logic ireq, iflush, dreq, dwe, ack,
                              input logic [31:0] mrd,
                              input logic emreq, emwe, input logic [31:0] emaddr,
                              input logic eir, edr,
                              input logic [31:0] eird, edrd);
    vec_t v;
    v.ireq = ireq; v.iflush = iflush; v.dreq = dreq; v.dwe = dwe; v.ack = ack;
    v.mrd = mrd; v.e_mreq = emreq; v.e_mwe = emwe; v.e_maddr = emaddr;
    v.e_ir = eir; v.e_dr = edr; v.e_irdata = eird; v.e_drdata = edrd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic idle_inputs();
    imem_req = 0; imem_flush = 0; dmem_req = 0; dmem_we = 0; mem_ack = 0; mem_rdata = 0;
  endtask

  // waits at negedges for mem_req, at most 'budget' cycles
  task automatic wait_mem_req(input string name, input int budget);
    int n = 0;
    while (!mem_req && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, mem_req}, 32'd1);
  endtask

  initial begin
    int dcount, nready, both, runs[2];
    logic [31:0] ctl_exp;

    // rows: inputs in this cycle | outputs expected in this cycle
    vt[0]  = mk(0,0,1,0,0,0,            0,0,32'h0,  0,0,32'h0,        32'h0);
    vt[1]  = mk(0,0,1,0,1,32'hDEADBEEF, 1,0,32'h100,0,0,32'h0,        32'h0);
    vt[2]  = mk(0,0,1,0,0,0,            0,0,32'h100,0,1,32'h0,        32'hDEADBEEF);
    vt[3]  = mk(0,0,0,0,0,0,            0,0,32'h100,0,0,32'h0,        32'hDEADBEEF);
    vt[4]  = mk(1,0,1,1,0,0,            0,0,32'h100,0,0,32'h0,        32'hDEADBEEF);
    vt[5]  = mk(1,0,1,1,1,32'h11111111, 1,1,32'h100,0,0,32'h0,        32'hDEADBEEF);
    vt[6]  = mk(1,0,1,1,0,0,            0,1,32'h100,0,1,32'h0,        32'h11111111);
    vt[7]  = mk(1,0,0,0,0,0,            0,1,32'h100,0,0,32'h0,        32'h11111111);
    vt[8]  = mk(1,0,0,0,1,32'hAAAA0001, 1,0,32'h40, 0,0,32'h0,        32'h11111111);
    vt[9]  = mk(1,0,0,0,0,0,            0,0,32'h40, 1,0,32'hAAAA0001, 32'h11111111);
    vt[10] = mk(0,0,0,0,0,0,            0,0,32'h40, 0,0,32'hAAAA0001, 32'h11111111);
    vt[11] = mk(1,0,0,0,0,0,            0,0,32'h40, 0,0,32'hAAAA0001, 32'h11111111);
    vt[12] = mk(1,1,0,0,0,0,            1,0,32'h40, 0,0,32'hAAAA0001, 32'h11111111);
    vt[13] = mk(0,0,0,0,0,0,            1,0,32'h40, 0,0,32'hAAAA0001, 32'h11111111);
    vt[14] = mk(0,0,0,0,0,0,            1,0,32'h40, 0,0,32'hAAAA0001, 32'h11111111);
    vt[15] = mk(0,0,0,0,1,32'hBBBBBBBB, 1,0,32'h40, 0,0,32'hAAAA0001, 32'h11111111);
    vt[16] = mk(0,0,0,0,0,0,            0,0,32'h40, 0,0,32'hAAAA0001, 32'h11111111);
    vt[17] = mk(1,0,0,0,0,0,            0,0,32'h40, 0,0,32'hAAAA0001, 32'h11111111);
    vt[18] = mk(1,1,0,0,1,32'hCCCCCCCC, 1,0,32'h40, 0,0,32'hAAAA0001, 32'h11111111);
    vt[19] = mk(0,0,0,0,0,0,            0,0,32'h40, 0,0,32'hAAAA0001, 32'h11111111);
    vt[20] = mk(1,0,0,0,0,0,            0,0,32'h40, 0,0,32'hAAAA0001, 32'h11111111);
    vt[21] = mk(1,0,0,0,1,32'h12345678, 1,0,32'h40, 0,0,32'hAAAA0001, 32'h11111111);
    vt[22] = mk(1,0,0,0,0,0,            0,0,32'h40, 1,0,32'h12345678, 32'h11111111);
    vt[23] = mk(0,0,0,0,1,32'hFFFFFFFF, 0,0,32'h40, 0,0,32'h12345678, 32'h11111111);
    vt[24] = mk(0,0,1,0,0,0,            0,0,32'h40, 0,0,32'h12345678, 32'h11111111);
    vt[25] = mk(0,1,1,0,1,32'hDDDD0000, 1,0,32'h100,0,0,32'h12345678, 32'h11111111);
    vt[26] = mk(0,1,1,0,1,32'hEEEEEEEE, 0,0,32'h100,0,1,32'h12345678, 32'hDDDD0000);
    vt[27] = mk(0,0,0,0,0,0,            0,0,32'h100,0,0,32'h12345678, 32'hDDDD0000);

    rst = 0;
    idle_inputs();
    imem_addr = 32'h40; dmem_addr = 32'h100; dmem_wdata = 32'h12345678; dmem_wmask = 4'h3;
    repeat (2) @(negedge clk);
    check("reset mem_req", {31'd0, mem_req}, 32'd0);
    check("reset readies", {30'd0, imem_ready, dmem_ready}, 32'd0);
    check("reset mem_addr", mem_addr, 32'd0);
    check("reset mem_wdata", mem_wdata, 32'd0);
    check("reset mem_we/wmask", {27'd0, mem_we, mem_wmask}, 32'd0);
    rst = 1;

    for (int k = 0; k < NV; k++) begin
      check($sformatf("v%0d mem_req", k),    {31'd0, mem_req},    {31'd0, vt[k].e_mreq});
      check($sformatf("v%0d mem_we", k),     {31'd0, mem_we},     {31'd0, vt[k].e_mwe});
      check($sformatf("v%0d mem_addr", k),   mem_addr,            vt[k].e_maddr);
      check($sformatf("v%0d imem_ready", k), {31'd0, imem_ready}, {31'd0, vt[k].e_ir});
      check($sformatf("v%0d dmem_ready", k), {31'd0, dmem_ready}, {31'd0, vt[k].e_dr});
      check($sformatf("v%0d imem_rdata", k), imem_rdata,          vt[k].e_irdata);
      check($sformatf("v%0d dmem_rdata", k), dmem_rdata,          vt[k].e_drdata);
      imem_req = vt[k].ireq; imem_flush = vt[k].iflush;
      dmem_req = vt[k].dreq; dmem_we = vt[k].dwe;
      mem_ack = vt[k].ack; mem_rdata = vt[k].mrd;
      @(negedge clk);
    end
    idle_inputs();
    @(negedge clk);

    // starvation: both requesters held; memory acks as soon as mem_req is seen
    imem_req = 1; dmem_req = 1; dmem_we = 0;
    dcount = 0; nready = 0; both = 0; runs[0] = -1; runs[1] = -1;
    for (int c = 0; c < 200 && nready < 2; c++) begin
      @(negedge clk);
      if (imem_ready && dmem_ready) both++;
      if (dmem_ready) dcount++;
      if (imem_ready) begin
        runs[nready] = dcount;
        dcount = 0;
        nready++;
      end
      mem_ack = mem_req;
      mem_rdata = 32'h5000 + c;
    end
    idle_inputs();
    check("starve first run dmem grants", runs[0], 32'd4);
    check("starve second run dmem grants", runs[1], 32'd4);
    check("starve both readies", both, 32'd0);
    repeat (3) @(negedge clk);

    // long memory stall on a store: fields frozen, exactly one ready pulse
    dmem_req = 1; dmem_we = 1; dmem_addr = 32'h200; dmem_wdata = 32'hA5A55A5A; dmem_wmask = 4'h5;
    @(negedge clk);
    wait_mem_req("stall grant", 10);
    ctl_exp = {26'd0, 4'h5, 1'b1, 1'b1};
    nready = 0;
    for (int c = 0; c < 10; c++) begin
      check("stall mem_addr", mem_addr, 32'h200);
      check("stall mem_wdata", mem_wdata, 32'hA5A55A5A);
      check("stall wmask/we/req", {26'd0, mem_wmask, mem_we, mem_req}, ctl_exp);
      if (dmem_ready || imem_ready) nready++;
      @(negedge clk);
    end
    mem_ack = 1; mem_rdata = 32'h0BADF00D;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      mem_ack = 0;
      if (imem_ready) nready++;
      if (dmem_ready) begin
        nready++;
        dmem_req = 0;
        check("stall store rdata", dmem_rdata, 32'h0BADF00D);
      end
    end
    check("stall ready pulses", nready, 32'd1);
    idle_inputs();

    // reset while DBUSY: mem_req drops at once, no ready after release
    dmem_req = 1; dmem_we = 0; dmem_addr = 32'h100;
    @(negedge clk);
    wait_mem_req("rst test grant", 10);
    #2 rst = 0;
    #1;
    check("async rst mem_req", {31'd0, mem_req}, 32'd0);
    check("async rst dmem_rdata", dmem_rdata, 32'd0);
    check("async rst mem_addr", mem_addr, 32'd0);
    @(negedge clk);
    dmem_req = 0; mem_ack = 1; rst = 1;
    nready = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      mem_ack = 0;
      if (dmem_ready || imem_ready || mem_req) nready++;
    end
    check("post-rst activity", nready, 32'd0);

    // first grant on the first edge after release
    rst = 0;
    @(negedge clk);
    dmem_req = 1; dmem_addr = 32'h300; rst = 1;
    @(negedge clk);
    check("first edge grant mem_req", {31'd0, mem_req}, 32'd1);
    check("first edge grant mem_addr", mem_addr, 32'h300);
    mem_ack = 1; mem_rdata = 32'h77;
    @(negedge clk);
    mem_ack = 0;
    check("first edge dmem_ready", {31'd0, dmem_ready}, 32'd1);
    dmem_req = 0;
    @(negedge clk);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
